trap_ctrl: RTL and testbench

TRAP_CTRL -- requirements
Module: trap_ctrl

---
 rtl/trap_ctrl.sv | 139 +++++++++++++
 tb/tb_trap_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/trap_ctrl.sv
// trap_ctrl: machine-mode trap/interrupt sequencer with pipeline stall control
module trap_ctrl #(
    parameter int XLEN = 32,
    parameter int NUM_LIRQ = 8,
    parameter logic [XLEN-1:0] REBOOT_ADDR = '0
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [6:0]      exception_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] ins_i,
    input  logic [3:0]      stallreq_i,
    input  logic            mstatus_ie_i,
    input  logic [XLEN-1:0] mie_i,
    input  logic [XLEN-1:0] mip_i,
    input  logic [XLEN-1:0] mtvec_i,
    input  logic [XLEN-1:0] epc_i,
    output logic [5:0]      stall_o,
    output logic            flush_o,
    output logic [XLEN-1:0] new_pc_o,
    output logic            set_cause_o,
    output logic [XLEN-1:0] cause_o,
    output logic            set_epc_o,
    output logic [XLEN-1:0] epc_o,
    output logic            set_mtval_o,
    output logic [XLEN-1:0] mtval_o,
    output logic            mstatus_ie_clear_o,
    output logic            mstatus_ie_set_o
);
    typedef enum logic [2:0] {RESET, OPERATING, DRAIN, TRAP_TAKEN, TRAP_RETURN} state_t;
    state_t state;
    logic trap_req, intr, taken, ret, unused_bits;
    logic [4:0] code;
    logic [XLEN-1:0] tval, cause_q, epc_q, mtval_q, base, vec;
    // Highest-priority pending source: later assignments override earlier ones
    always_comb begin
        trap_req = 1'b0;
        intr = 1'b0;
        code = '0;
        tval = '0;
        for (int i = NUM_LIRQ - 1; i >= 0; i--)
            if (mstatus_ie_i && mie_i[16 + i] && mip_i[16 + i]) begin
                trap_req = 1'b1;
                intr = 1'b1;
                code = 5'(16 + i);
            end
        if (mstatus_ie_i && mie_i[7] && mip_i[7]) begin
            trap_req = 1'b1;
            intr = 1'b1;
            code = 5'd7;
        end
        if (mstatus_ie_i && mie_i[3] && mip_i[3]) begin
            trap_req = 1'b1;
            intr = 1'b1;
            code = 5'd3;
        end
        if (mstatus_ie_i && mie_i[11] && mip_i[11]) begin
            trap_req = 1'b1;
            intr = 1'b1;
            code = 5'd11;
        end
        if (exception_i[1]) begin
            trap_req = 1'b1;
            intr = 1'b0;
            code = 5'd11;
        end
        if (exception_i[5]) begin
            trap_req = 1'b1;
            intr = 1'b0;
            code = 5'd6;
            tval = pc_i;
        end
        if (exception_i[6]) begin
            trap_req = 1'b1;
            intr = 1'b0;
            code = 5'd4;
            tval = pc_i;
        end
        if (exception_i[2]) begin
            trap_req = 1'b1;
            intr = 1'b0;
            code = 5'd3;
            tval = pc_i;
        end
        if (exception_i[4]) begin
            trap_req = 1'b1;
            intr = 1'b0;
            code = 5'd2;
            tval = ins_i;
        end
        if (exception_i[3]) begin
            trap_req = 1'b1;
            intr = 1'b0;
            code = 5'd0;
            tval = pc_i;
        end
    end
    // Sequencer; trap details are latched once when leaving OPERATING and held through DRAIN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= RESET;
            cause_q <= '0;
            epc_q <= '0;
            mtval_q <= '0;
        end else begin
            case (state)
                RESET: state <= OPERATING;
                OPERATING: begin
                    if (trap_req) begin
                        cause_q <= {intr, {(XLEN-6){1'b0}}, code};
                        epc_q <= pc_i;
                        mtval_q <= tval;
                        state <= stallreq_i[3] ? DRAIN : TRAP_TAKEN;
                    end else if (exception_i[0] && !stallreq_i[3]) begin
                        state <= TRAP_RETURN;
                    end
                end
                DRAIN: state <= stallreq_i[3] ? DRAIN : TRAP_TAKEN;
                default: state <= OPERATING;
            endcase
        end
    end
    assign unused_bits = ^{mie_i, mip_i};
    assign taken = state == TRAP_TAKEN;
    assign ret = state == TRAP_RETURN;
    assign base = {mtvec_i[XLEN-1:2], 2'b00};
    assign vec = (mtvec_i[1:0] == 2'b01 && cause_q[XLEN-1]) ? base + XLEN'({cause_q[4:0], 2'b00}) : base;
    assign new_pc_o = state == RESET ? REBOOT_ADDR : taken ? vec : ret ? epc_i : '0;
    assign stall_o = rst_i ? 6'b0 : stallreq_i[3] ? 6'b011111 : stallreq_i[2] ? 6'b001111 : |stallreq_i[1:0] ? 6'b000111 : 6'b0;
    assign flush_o = taken | ret;
    assign set_cause_o = taken;
    assign set_epc_o = taken;
    assign set_mtval_o = taken;
    assign mstatus_ie_clear_o = taken;
    assign mstatus_ie_set_o = ret;
    assign cause_o = cause_q;
    assign epc_o = epc_q;
    assign mtval_o = mtval_q;
endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl: directed and randomized checks of trap_ctrl against a behavioural model
module tb_trap_ctrl;
    localparam logic [31:0] REBOOT = 32'h8000_0000;
    logic clk = 0, rst = 1, ie = 0, flush, set_cause, set_epc, set_mtval, ie_clr, ie_set;
    logic [6:0] exc = 0;
    logic [3:0] sreq = 0;
    logic [5:0] stall;
    logic [31:0] pc = 0, ins = 0, mie = 0, mip = 0, mtvec = 0, epc = 0;
    logic [31:0] new_pc, cause, epc_out, mtval;
    int n_checks = 0, n_fail = 0;
    int ms = 0;
    logic [31:0] m_cause = 0, m_epc = 0, m_mtval = 0;

    always #5 clk = ~clk;

    trap_ctrl #(.XLEN(32), .NUM_LIRQ(8), .REBOOT_ADDR(REBOOT)) dut (
        .clk_i(clk), .rst_i(rst), .exception_i(exc), .pc_i(pc), .ins_i(ins),
        .stallreq_i(sreq), .mstatus_ie_i(ie), .mie_i(mie), .mip_i(mip),
        .mtvec_i(mtvec), .epc_i(epc), .stall_o(stall), .flush_o(flush),
        .new_pc_o(new_pc), .set_cause_o(set_cause), .cause_o(cause),
        .set_epc_o(set_epc), .epc_o(epc_out), .set_mtval_o(set_mtval),
        .mtval_o(mtval), .mstatus_ie_clear_o(ie_clr), .mstatus_ie_set_o(ie_set)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Priority table scanned first-match: sources listed highest priority first
    task automatic pick(output logic found, output logic [31:0] c, output logic [31:0] v);
        logic hit[17];
        logic [31:0] cs[17], vs[17];
        hit[0] = exc[3]; cs[0] = 0;  vs[0] = pc;
        hit[1] = exc[4]; cs[1] = 2;  vs[1] = ins;
        hit[2] = exc[2]; cs[2] = 3;  vs[2] = pc;
        hit[3] = exc[6]; cs[3] = 4;  vs[3] = pc;
        hit[4] = exc[5]; cs[4] = 6;  vs[4] = pc;
        hit[5] = exc[1]; cs[5] = 11; vs[5] = 0;
        hit[6] = ie & mie[11] & mip[11]; cs[6] = 32'h8000_000B; vs[6] = 0;
        hit[7] = ie & mie[3] & mip[3];   cs[7] = 32'h8000_0003; vs[7] = 0;
        hit[8] = ie & mie[7] & mip[7];   cs[8] = 32'h8000_0007; vs[8] = 0;
        for (int i = 0; i < 8; i++) begin
            hit[9+i] = ie & mie[16+i] & mip[16+i];
            cs[9+i] = 32'h8000_0000 + 32'(16 + i);
            vs[9+i] = 0;
        end
        found = 0; c = 0; v = 0;
        for (int i = 0; i < 17; i++)
            if (hit[i] && !found) begin
                found = 1; c = cs[i]; v = vs[i];
            end
    endtask

    task automatic check_all();
        logic [31:0] exp_pc, b;
        logic [5:0] exp_stall;
        b = mtvec & ~32'h3;
        exp_pc = 0;
        if (ms == 0) exp_pc = REBOOT;
        if (ms == 3) exp_pc = (mtvec[1:0] == 2'b01 && m_cause[31]) ? b + 4 * (m_cause & 32'h1F) : b;
        if (ms == 4) exp_pc = epc;
        exp_stall = rst ? 6'h00 : sreq[3] ? 6'h1F : sreq[2] ? 6'h0F : (sreq[1] | sreq[0]) ? 6'h07 : 6'h00;
        check("stall", 32'(stall), 32'(exp_stall));
        check("flush", 32'(flush), 32'(ms == 3 || ms == 4));
        check("new_pc", new_pc, exp_pc);
        check("set_cause", 32'(set_cause), 32'(ms == 3));
        check("set_epc", 32'(set_epc), 32'(ms == 3));
        check("set_mtval", 32'(set_mtval), 32'(ms == 3));
        check("ie_clear", 32'(ie_clr), 32'(ms == 3));
        check("ie_set", 32'(ie_set), 32'(ms == 4));
        check("cause", cause, m_cause);
        check("epc", epc_out, m_epc);
        check("mtval", mtval, m_mtval);
    endtask

    // Check current outputs, advance the model across one rising edge, return at the falling edge
    task automatic cycle();
        logic f;
        logic [31:0] c, v;
        int nms;
        #1;
        check_all();
        pick(f, c, v);
        nms = ms;
        if (rst) begin
            nms = 0;
        end else if (ms == 0) begin
            nms = 1;
        end else if (ms == 1) begin
            if (f) nms = sreq[3] ? 2 : 3;
            else if (exc[0] && !sreq[3]) nms = 4;
        end else if (ms == 2) begin
            nms = sreq[3] ? 2 : 3;
        end else begin
            nms = 1;
        end
        @(posedge clk);
        if (rst) begin
            m_cause = 0; m_epc = 0; m_mtval = 0;
        end else if (ms == 1 && f) begin
            m_cause = c; m_epc = pc; m_mtval = v;
        end
        ms = nms;
        @(negedge clk);
    endtask

    task automatic quiet();
        exc = 0; sreq = 0; ie = 0; mie = 0; mip = 0;
    endtask

    initial begin
        @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_new_pc", new_pc, REBOOT);
        check("rst_flush", 32'(flush), 0);
        check("rst_cause", cause, 0);
        rst = 0;
        cycle();
        exc = 7'b0000010; pc = 32'h100; mtvec = 32'h200;
        cycle();
        #1;
        check("ecall_pc", new_pc, 32'h200);
        check("ecall_cause", cause, 11);
        check("ecall_epc", epc_out, 32'h100);
        check("ecall_mtval", mtval, 0);
        check("ecall_flush", 32'(flush), 1);
        quiet();
        cycle();
        mtvec = 32'h201; ie = 1; mie = 32'h80; mip = 32'h80;
        cycle();
        #1;
        check("mti_pc", new_pc, 32'h21C);
        check("mti_cause", cause, 32'h8000_0007);
        quiet();
        cycle();
        exc = 7'b0010000; ins = 32'hFFFF_FFFF; pc = 32'h44; sreq = 4'b1000;
        cycle();
        exc = 7'b0000010;
        for (int i = 0; i < 2; i++) begin
            cycle();
            #1;
            check("drain_flush", 32'(flush), 0);
        end
        quiet();
        cycle();
        #1;
        check("ill_cause", cause, 2);
        check("ill_mtval", mtval, 32'hFFFF_FFFF);
        check("ill_pc", new_pc, 32'h200);
        cycle();
        ie = 1; mie = 32'h0005_0800; mip = 32'h0005_0800;
        cycle();
        #1;
        check("mei_cause", cause, 32'h8000_000B);
        quiet();
        cycle();
        ie = 1; mie = 32'h0005_0000; mip = 32'h0005_0000;
        cycle();
        #1;
        check("lirq_cause", cause, 32'h8000_0010);
        quiet();
        cycle();
        exc = 7'b0000001; epc = 32'h400;
        cycle();
        #1;
        check("mret_pc", new_pc, 32'h400);
        check("mret_ie_set", 32'(ie_set), 1);
        check("mret_set_cause", 32'(set_cause), 0);
        quiet();
        cycle();
        exc = 7'b0000011;
        cycle();
        #1;
        check("mret_ecall_set", 32'(set_cause), 1);
        check("mret_ecall_cause", cause, 11);
        quiet();
        cycle();
        exc = 7'b0010000; sreq = 4'b1000;
        cycle();
        rst = 1;
        cycle();
        #1;
        check("drain_rst_pc", new_pc, REBOOT);
        check("drain_rst_set", 32'(set_cause), 0);
        check("drain_rst_cause", cause, 0);
        rst = 0;
        quiet();
        cycle();
        for (int n = 0; n < 3000; n++) begin
            for (int b = 0; b < 7; b++) exc[b] = ($urandom_range(0, 9) == 0);
            pc = $urandom; ins = $urandom; epc = $urandom;
            mtvec = $urandom;
            sreq = 4'($urandom);
            ie = ($urandom_range(0, 3) == 0);
            mie = $urandom;
            mip = $urandom & $urandom;
            rst = ($urandom_range(0, 39) == 0);
            cycle();
        end
        rst = 0;
        quiet();
        cycle();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
